// File: rtl/mem_seq.sv
// mem_seq: sequences word/half/byte reads and writes to a fixed-latency single-port memory
module mem_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [1:0]  Size,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr,
  output logic [31:0] RData,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut,
  output logic [2:0]  State_out
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR      = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_addr, r_wword, r_rdata;
  logic [1:0]    r_size;
  logic          r_write;
  logic [CW-1:0] r_cnt;
  logic          w_aligned, w_partial, w_accept, w_byte, w_half;
  logic [31:0]   w_extract, w_merged;

  assign w_aligned = (Size == 2'b10) | ((Size == 2'b01) ? ~Addr[0] : (Addr[1:0] == 2'b00));
  assign w_partial = (Size == 2'b01) | (Size == 2'b10);
  assign w_accept  = (r_state == IDLE) & Req;
  assign w_byte    = r_size == 2'b10;
  assign w_half    = r_size == 2'b01;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and per-state handshake/strobe outputs
  always_comb begin
    w_next   = r_state;
    Busy     = 1'b1;
    Done     = 1'b0;
    AlignErr = 1'b0;
    MemWr    = 1'b0;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) w_next = !w_aligned ? ERR : (ReqWrite && !w_partial) ? WR : RD_WAIT;
      end
      RD_WAIT: if (r_cnt == '0) w_next = r_write ? WR : DONE;
      WR: begin
        MemWr  = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        Done     = 1'b1;
        AlignErr = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Lane extraction for reads and lane merge for partial writes
  always_comb begin
    w_extract = w_byte ? {24'b0, MemDataOut[{r_addr[1:0], 3'b000} +: 8]} :
                w_half ? {16'b0, MemDataOut[{r_addr[1], 4'b0000} +: 16]} : MemDataOut;
    w_merged  = MemDataOut;
    if (w_byte) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wword[7:0];
    else if (w_half) w_merged[{r_addr[1], 4'b0000} +: 16] = r_wword[15:0];
  end

  // Request capture, latency countdown, read result and write word
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
      r_wword <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_addr  <= Addr;
      r_size  <= Size;
      r_write <= ReqWrite;
      r_cnt   <= CW'(MEM_LAT - 1);
      r_wword <= WData;
    end else if (r_state == RD_WAIT) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      else if (r_write) r_wword <= w_merged;
      else r_rdata <= w_extract;
    end
  end

  assign RData     = r_rdata;
  assign MemAddr   = {r_addr[31:2], 2'b00};
  assign MemDataIn = r_wword;
  assign State_out = r_state;
endmodule
